// File: rtl/out_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_shifter_if
//  Description : Output-byte and serial-pin bundle between the output
//                selector side and the 74HC595-style serialiser.
//  Revision    : 1.0  initial release
// ============================================================================
interface out_shifter_if;
  logic [7:0] out_latch;
  logic       resend;      // single-cycle request to resend the current byte
  logic       sclk;
  logic       sdata;
  logic       rclk;
  logic       busy;
  logic       frame_done;

  modport master (
    output out_latch,
    output resend,
    input  sclk,
    input  sdata,
    input  rclk,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  out_latch,
    input  resend,
    output sclk,
    output sdata,
    output rclk,
    output busy,
    output frame_done
  );
endinterface
`default_nettype wire

// File: rtl/out_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : out_shifter
//  Description : Shifts the output latch byte into an external 74HC595-style
//                chain (sclk/sdata/rclk) whenever it changes or a resend is due.
//  Revision    : 1.0  initial release
// ============================================================================
module out_shifter #(
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic    clk,
  input  wire logic    rst,
  out_shifter_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] c_s_idle     = 3'd0;
  localparam logic [2:0] c_s_shift_lo = 3'd1;
  localparam logic [2:0] c_s_shift_hi = 3'd2;
  localparam logic [2:0] c_s_strobe   = 3'd3;
  localparam logic [2:0] c_s_done     = 3'd4;

  logic [2:0]       r_state;
  logic [7:0]       r_last_sent;
  logic             r_pending;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             r_sdata;
  logic             r_rclk;
  logic             r_busy;
  logic             r_frame_done;

  logic [2:0]       w_state_nxt;
  logic [7:0]       w_last_sent_nxt;
  logic             w_pending_nxt;
  logic [7:0]       w_shift_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [DIV_W-1:0] w_div_cnt_nxt;
  logic             w_sclk_nxt;
  logic             w_sdata_nxt;
  logic             w_rclk_nxt;
  logic             w_busy_nxt;
  logic             w_frame_done_nxt;

  logic             w_changed;
  logic             w_trigger;
  logic             w_div_done;
  logic [7:0]       w_shifted;

  assign w_changed  = (bus.out_latch != r_last_sent);
  assign w_trigger  = w_changed | bus.resend | r_pending;
  assign w_div_done = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_shifted  = MSB_FIRST ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};

  // Next-state and datapath
  always_comb begin
    w_state_nxt     = r_state;
    w_last_sent_nxt = r_last_sent;
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_div_cnt_nxt   = w_div_done ? '0 : r_div_cnt + DIV_W'(1);
    // Any change or resend seen mid-frame collapses into one follow-up frame.
    w_pending_nxt   = r_pending | w_changed | bus.resend;

    case (r_state)
      c_s_idle: begin
        w_div_cnt_nxt = '0;
        w_pending_nxt = r_pending;
        if (w_trigger) begin
          w_state_nxt     = c_s_shift_lo;
          w_shift_nxt     = bus.out_latch;
          w_last_sent_nxt = bus.out_latch;
          w_pending_nxt   = 1'b0;
          w_bit_cnt_nxt   = 3'd0;
        end
      end
      c_s_shift_lo: begin
        if (w_div_done) w_state_nxt = c_s_shift_hi;
      end
      c_s_shift_hi: begin
        if (w_div_done) begin
          w_shift_nxt = w_shifted;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = c_s_strobe;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_state_nxt   = c_s_shift_lo;
          end
        end
      end
      c_s_strobe: begin
        if (w_div_done) w_state_nxt = c_s_done;
      end
      c_s_done: begin
        w_div_cnt_nxt = '0;
        w_state_nxt   = c_s_idle;
      end
      default: begin
        w_div_cnt_nxt = '0;
        w_state_nxt   = c_s_idle;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins themselves are flops.
  always_comb begin
    w_sclk_nxt       = (w_state_nxt == c_s_shift_hi);
    w_rclk_nxt       = (w_state_nxt == c_s_strobe);
    w_busy_nxt       = (w_state_nxt != c_s_idle);
    w_frame_done_nxt = (w_state_nxt == c_s_done);
    w_sdata_nxt      = 1'b0;
    if ((w_state_nxt == c_s_shift_lo) || (w_state_nxt == c_s_shift_hi)) begin
      w_sdata_nxt = MSB_FIRST ? w_shift_nxt[7] : w_shift_nxt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_s_idle;
      r_last_sent  <= 8'h00;
      r_pending    <= 1'b1;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_div_cnt    <= '0;
      r_sclk       <= 1'b0;
      r_sdata      <= 1'b0;
      r_rclk       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_sent  <= w_last_sent_nxt;
      r_pending    <= w_pending_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_div_cnt    <= w_div_cnt_nxt;
      r_sclk       <= w_sclk_nxt;
      r_sdata      <= w_sdata_nxt;
      r_rclk       <= w_rclk_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.sclk       = r_sclk;
  assign bus.sdata      = r_sdata;
  assign bus.rclk       = r_rclk;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_out_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_shifter
//  Description : Scoreboard bench for out_shifter; channel 0 is CLK_DIV=2 MSB
//                first, channel 1 is CLK_DIV=1 LSB first.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_out_shifter;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  out_shifter_if bus_a ();
  out_shifter_if bus_b ();

  out_shifter #(.CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
  out_shifter #(.CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: rebuild each frame from the pins and compare at frame_done.
  initial begin
    logic [7:0] acc[2];
    int nbits[2], rlen[2], blen[2], ovl[2], cd[2], msb[2];
    logic prev_s[2];
    logic s, sd, r, b, fd, rs;
    logic [7:0] expv;
    int qs;
    cd[0] = 2; cd[1] = 1; msb[0] = 1; msb[1] = 0;
    for (int c = 0; c < 2; c++) begin
      acc[c] = 8'h00; nbits[c] = 0; rlen[c] = 0; blen[c] = 0; ovl[c] = 0; prev_s[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (c == 0) begin
          s = bus_a.sclk; sd = bus_a.sdata; r = bus_a.rclk; b = bus_a.busy; fd = bus_a.frame_done; rs = rst_a;
        end else begin
          s = bus_b.sclk; sd = bus_b.sdata; r = bus_b.rclk; b = bus_b.busy; fd = bus_b.frame_done; rs = rst_b;
        end
        if (rs) begin
          acc[c] = 8'h00; nbits[c] = 0; rlen[c] = 0; blen[c] = 0; ovl[c] = 0;
        end else begin
          if (s === 1'b1 && prev_s[c] === 1'b0) begin
            nbits[c]++;
            acc[c] = (msb[c] == 1) ? {acc[c][6:0], sd} : {sd, acc[c][7:1]};
          end
          if (r === 1'b1) rlen[c]++;
          if (b === 1'b1) blen[c]++;
          if (s === 1'b1 && r === 1'b1) ovl[c]++;
          if (fd === 1'b1) begin
            qs = (c == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
              check($sformatf("ch%0d_unexpected_frame", c), acc[c], -1);
            end else begin
              expv = (c == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("ch%0d_frame_data", c), acc[c], expv);
              check($sformatf("ch%0d_bit_count", c), nbits[c], 8);
              check($sformatf("ch%0d_rclk_cycles", c), rlen[c], cd[c]);
              check($sformatf("ch%0d_busy_cycles", c), blen[c], 17 * cd[c] + 1);
              check($sformatf("ch%0d_sclk_rclk_overlap", c), ovl[c], 0);
            end
            acc[c] = 8'h00; nbits[c] = 0; rlen[c] = 0; ovl[c] = 0;
          end
          if (b !== 1'b1) blen[c] = 0;
        end
        prev_s[c] = s;
      end
    end
  end

  // Wait until the channel's expectations are consumed and it stays idle.
  task automatic settle(input int c);
    int quiet = 0;
    bit ok = 0;
    logic b;
    int qs;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      b  = (c == 0) ? bus_a.busy : bus_b.busy;
      qs = (c == 0) ? q0.size() : q1.size();
      if (qs == 0 && b === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 40) ok = 1;
    end
    if (!ok) check($sformatf("ch%0d_settle_timeout", c), qs, 0);
  endtask

  task automatic check_quiet_pins(input string tag);
    check({tag, "_sclk"}, bus_a.sclk, 0);
    check({tag, "_rclk"}, bus_a.rclk, 0);
    check({tag, "_busy"}, bus_a.busy, 0);
    check({tag, "_frame_done"}, bus_a.frame_done, 0);
  endtask

  initial begin
    int edges;
    logic prev;
    bus_a.out_latch = 8'h00; bus_a.resend = 1'b0;
    bus_b.out_latch = 8'h81; bus_b.resend = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_quiet_pins("reset_a");
    check("reset_a_sdata", bus_a.sdata, 0);
    check("reset_b_busy", bus_b.busy, 0);
    check("reset_b_sclk", bus_b.sclk, 0);
    check("reset_b_rclk", bus_b.rclk, 0);

    // Initialising frames after reset
    q0.push_back(8'h00);
    q1.push_back(8'h81);
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    settle(0);

    q0.push_back(8'hA5);
    tick(); bus_a.out_latch = 8'hA5;
    settle(0);

    // Mid-frame changes coalesce into one frame with the latest value
    q0.push_back(8'h01);
    tick(); bus_a.out_latch = 8'h01;
    repeat (10) tick();
    bus_a.out_latch = 8'h02;
    repeat (5) tick();
    bus_a.out_latch = 8'h04;
    q0.push_back(8'h04);
    settle(0);

    q0.push_back(8'h3C);
    tick(); bus_a.out_latch = 8'h3C;
    settle(0);
    q0.push_back(8'h3C);
    tick(); bus_a.resend = 1'b1;
    tick(); bus_a.resend = 1'b0;
    settle(0);

    q0.push_back(8'h55);
    tick(); bus_a.out_latch = 8'h55; bus_a.resend = 1'b1;
    tick(); bus_a.resend = 1'b0;
    settle(0);

    // Reset in the middle of bit 4 of an 0xFF frame
    q0.push_back(8'hFF);
    tick(); bus_a.out_latch = 8'hFF;
    edges = 0;
    prev = 1'b0;
    for (int i = 0; i < 200 && edges < 4; i++) begin
      tick();
      if (bus_a.sclk === 1'b1 && prev === 1'b0) edges++;
      prev = bus_a.sclk;
    end
    check("abort_reach_bit4", edges, 4);
    tick(); tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    @(negedge clk);
    check_quiet_pins("abort");
    settle(0);

    settle(1);
    q1.push_back(8'h03);
    tick(); bus_b.out_latch = 8'h03;
    settle(1);

    check("q0_leftover", q0.size(), 0);
    check("q1_leftover", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_shifter.md
# out_shifter

Serialises the 8-bit output latch of the output selector onto an external 74HC595-style shift register chain using three pins (serial clock, serial data, register strobe). Sits directly downstream of the output selector: it watches the latched byte, and whenever the value changes or a refresh is forced, it shifts the new byte out and strobes it into the external register. Changes arriving mid-transfer are coalesced, and the latest value is always sent next.

## Interface
Parameters:
- CLK_DIV, default 2: system clocks per sclk half-period; legal range 1..255.
- MSB_FIRST, default 1: 1 shifts bit 7 first, 0 shifts bit 0 first.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- out_latch  in  8  byte from the output selector.
- force  in  1  single-cycle request to resend the current byte even if unchanged.
- sclk  out  1  serial clock; external device samples sdata on its rising edge.
- sdata  out  1  serial data.
- rclk  out  1  register strobe; external outputs update on its rising edge.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- Internal state:
  - last_sent[7:0]: last byte strobed out.
  - pending: a resend is owed.
  - shift[7:0]: shift register.
  - bit_cnt[2:0]: bit counter.
  - div_cnt: divider counter, sized to hold CLK_DIV-1.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, STROBE, DONE.
- Trigger condition: (out_latch != last_sent) | force | pending.
- IDLE: on trigger, shift <= out_latch, last_sent <= out_latch, pending <= 0, bit_cnt <= 0, div_cnt <= 0, go to SHIFT_LO.
- SHIFT_LO: sclk=0, sdata = current bit (shift[7] if MSB_FIRST, else shift[0]). After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI: sclk=1, sdata held. After CLK_DIV cycles:
  - shift the register by one bit.
  - if bit_cnt==7, go to STROBE; otherwise bit_cnt++ and go to SHIFT_LO.
- STROBE: sclk=0, rclk=1 for CLK_DIV cycles, then go to DONE.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- Change during a frame (not IDLE, out_latch != last_sent) or force during a frame: set pending. Multiple changes collapse into one follow-up frame carrying the value of out_latch at the IDLE cycle.
- Reset sets pending=1, so one initialising frame always follows reset. This guarantees the external register matches the internal state.

## Timing
- Reset values:
  - sclk=0, sdata=0, rclk=0, busy=0, frame_done=0.
  - last_sent=0x00, pending=1, state IDLE.
- Trigger seen in IDLE at cycle T: busy=1 and the first bit is on sdata from cycle T+1.
- Bit k (k=0..7):
  - sclk low during cycles T+1+2k·CLK_DIV .. +CLK_DIV-1.
  - sclk high for the following CLK_DIV cycles.
  - sdata stable across the whole bit, so it is valid at each sclk rising edge.
- rclk high during cycles T+1+16·CLK_DIV .. T+17·CLK_DIV.
- frame_done at cycle T+1+17·CLK_DIV.
- busy duration: 17·CLK_DIV+1 cycles (35 at CLK_DIV=2).
- IDLE returns at T+2+17·CLK_DIV. A pending frame starts with its trigger evaluated in that cycle, giving one idle cycle minimum between frames.
- sclk and rclk are never high in the same cycle. All outputs are registered, with no combinational paths from inputs.
- rst asserted mid-frame: next cycle all outputs return to reset values, busy=0, no frame_done. The initialising frame then restarts from IDLE with the current out_latch.
- force asserted in the same cycle as a change in IDLE: exactly one frame starts.

## Test plan
- Reset, out_latch=0x00, CLK_DIV=2 -> one frame of eight 0 bits; rclk high for 2 cycles; frame_done pulses once; busy high exactly 35 cycles; then IDLE with no further frames.
- out_latch 0x00→0xA5, MSB_FIRST=1 -> sdata at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; then a single rclk pulse; last_sent=0xA5.
- During a frame sending 0x01, out_latch goes 0x02 then 0x04 -> after the first frame_done, exactly one more frame carrying 0x04; no 0x02 frame.
- IDLE with out_latch=last_sent=0x3C, one-cycle force -> one frame carrying 0x3C; holding out_latch stable afterwards produces no further frames.
- rst asserted at bit 4 of a 0xFF frame -> next cycle sclk=rclk=busy=0; no rclk pulse for the aborted frame; the initialising frame then sends 0xFF in full.
- MSB_FIRST=0, CLK_DIV=1, out_latch=0x81→0x03 -> bits 1,1,0,0,0,0,0,0; busy 18 cycles.
